// File: rtl/match_window_counter.sv
// match_window_counter
//   Counts one-cycle match pulses from the 1101 sequence detector over
//   back-to-back frames of WINDOW clock cycles and hands each frame count to
//   the next stage through a one-entry valid/ready buffer. A frame that
//   closes while the buffer is still occupied is lost and the sticky
//   `dropped` flag is set.
//
//   Optional feature macro: MATCH_CNT_SAT_EN
//     defined   -> the accumulator saturates at 2^CW-1
//     undefined -> the accumulator wraps modulo 2^CW
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | counting disabled; wcnt/acc held at 0, match ignored
//   RUN   | counting a frame; close edge at wcnt == WINDOW-1
module match_window_counter #(
    parameter int WINDOW = 16,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          match,
    input  logic          enable,
    output logic [CW-1:0] cnt_data,
    output logic          cnt_valid,
    input  logic          cnt_ready,
    output logic          dropped
);

    localparam int WW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          dropped_q, dropped_d;
    logic [CW-1:0] acc_inc;
    logic          consume;

`ifdef MATCH_CNT_SAT_EN
    logic [CW:0] acc_sum;

    // Saturating increment: a carry out pins the accumulator at all-ones.
    always_comb begin
        acc_sum = {1'b0, acc_q} + (CW + 1)'(match);
        acc_inc = acc_sum[CW] ? {CW{1'b1}} : acc_sum[CW-1:0];
    end
`else
    // Wrapping increment modulo 2^CW.
    always_comb begin
        acc_inc = acc_q + CW'(match);
    end
`endif

    // Next-state logic for the frame FSM, counters and output buffer.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        acc_d     = acc_q;
        data_d    = data_q;
        valid_d   = valid_q;
        dropped_d = dropped_q;
        consume   = valid_q & cnt_ready;

        // A consume with no load at this edge empties the buffer; a load
        // below overrides this so a simultaneous consume+load has no bubble.
        if (consume) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                acc_d  = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Abort: partial frame is discarded, buffer untouched.
                    state_d = IDLE;
                    wcnt_d  = '0;
                    acc_d   = '0;
                end else if (wcnt_q == WLAST) begin
                    wcnt_d = '0;
                    acc_d  = '0;
                    if (!valid_q || consume) begin
                        data_d  = acc_inc;
                        valid_d = 1'b1;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                    acc_d  = acc_inc;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
                acc_d   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign cnt_data  = data_q;
    assign cnt_valid = valid_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Testbench for match_window_counter (WINDOW=8, CW=3).
// Expected outputs come from a frame-level model: matches of the current
// frame are collected in a queue and summed when the queue holds WINDOW
// entries; the output buffer is modelled as a valid bit plus a value.
module tb_match_window_counter;

    localparam int W    = 8;
    localparam int CW   = 3;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          match;
    logic          enable;
    logic          cnt_ready;
    logic [CW-1:0] cnt_data;
    logic          cnt_valid;
    logic          dropped;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit running;
    bit mframe[$];
    bit mv;
    bit mdrop;
    int md;

    match_window_counter #(.WINDOW(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .match     (match),
        .enable    (enable),
        .cnt_data  (cnt_data),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int frame_result();
        int s = 0;
        foreach (mframe[i]) s += int'(mframe[i]);
`ifdef MATCH_CNT_SAT_EN
        if (s > MAXV) s = MAXV;
`else
        s = s % (MAXV + 1);
`endif
        return s;
    endfunction

    task automatic model_reset();
        running = 1'b0;
        mframe.delete();
        mv    = 1'b0;
        mdrop = 1'b0;
        md    = 0;
    endtask

    task automatic model_edge(input bit m, input bit e, input bit r);
        bit close = 1'b0;
        bit cons  = mv & r;
        int res   = 0;
        if (running) begin
            if (e) begin
                mframe.push_back(m);
                if (mframe.size() == W) begin
                    close = 1'b1;
                    res   = frame_result();
                    mframe.delete();
                end
            end else begin
                running = 1'b0;
                mframe.delete();
            end
        end else if (e) begin
            running = 1'b1;
            mframe.delete();
        end
        if (close) begin
            if (!mv || cons) begin
                md = res;
                mv = 1'b1;
            end else begin
                mdrop = 1'b1;
            end
        end else if (cons) begin
            mv = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("cnt_valid", cnt_valid, mv);
        chk("cnt_data", cnt_data, md);
        chk("dropped", dropped, mdrop);
    endtask

    task automatic step(input bit m, input bit e, input bit r);
        match     = m;
        enable    = e;
        cnt_ready = r;
        @(posedge clk);
        model_edge(m, e, r);
        #1;
        compare_all();
    endtask

    task automatic run_frame(input int n, input bit r);
        for (int i = 0; i < W; i++) step(i < n, 1'b1, r);
    endtask

    initial begin
        int ovf_exp;
`ifdef MATCH_CNT_SAT_EN
        ovf_exp = MAXV;
`else
        ovf_exp = 0;
`endif
        rst       = 1'b0;
        match     = 1'b0;
        enable    = 1'b0;
        cnt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;

        // basic count: matches in RUN cycles 0, 3, 6
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) step(i == 0 || i == 3 || i == 6, 1'b1, 1'b1);
        chk("basic_valid", cnt_valid, 1);
        chk("basic_data", cnt_data, 3);

        // overflow: next frame back to back, match held high throughout
        run_frame(W, 1'b1);
        chk("overflow_data", cnt_data, ovf_exp);

        // backpressure: counts 2 then 5 with ready low
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(5, 1'b0);
        chk("bp_data", cnt_data, 2);
        chk("bp_dropped", dropped, 1);
        step(1'b0, 1'b1, 1'b1);
        chk("bp_valid_fall", cnt_valid, 0);
        for (int i = 0; i < W - 1; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // async reset mid-frame with valid and dropped set
        chk("pre_rst_valid", cnt_valid, 1);
        chk("pre_rst_dropped", dropped, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_data", cnt_data, 0);
        chk("rst_valid", cnt_valid, 0);
        chk("rst_dropped", dropped, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);

        // abort at RUN cycle 4 after two matches
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("abort_valid", cnt_valid, 0);
        step(1'b0, 1'b1, 1'b1);
        run_frame(1, 1'b1);
        chk("abort_next_data", cnt_data, 1);

        // simultaneous consume and load: 4 held, then 6 loaded on consume
        run_frame(4, 1'b1);
        chk("sim_pre_data", cnt_data, 4);
        for (int i = 0; i < W - 1; i++) step(i < 6, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("sim_data", cnt_data, 6);
        chk("sim_valid", cnt_valid, 1);
        chk("sim_dropped", dropped, 0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
